// File: rtl/llc_stub_pkg.sv
// Shared types and constants for the single-sharer LLC stub responder.
// Holds the coherence message codes, the FSM state enum and the request-to-response mapping.
package llc_stub_pkg;

   localparam int LINE_ADDR_BITS  = 28;
   localparam int BITS_PER_LINE   = 128;
   localparam int INVACK_CNT_BITS = 2;

   localparam logic [1:0] REQ_GETS = 2'b00;
   localparam logic [1:0] REQ_GETM = 2'b01;
   localparam logic [1:0] REQ_PUTS = 2'b10;
   localparam logic [1:0] REQ_PUTM = 2'b11;

   localparam logic [1:0] RSP_DATA   = 2'b00;
   localparam logic [1:0] RSP_EDATA  = 2'b01;
   localparam logic [1:0] RSP_PUTACK = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_MEM_REQ = 2'd1,
      ST_MEM_RSP = 2'd2,
      ST_RSP     = 2'd3
   } llc_state_t;

   // GetS is granted exclusive because this stub is always the only sharer.
   function automatic logic [1:0] rsp_for_req(input logic [1:0] msg);
      logic [1:0] rsp;
      case (msg)
         REQ_GETS: rsp = RSP_EDATA;
         REQ_GETM: rsp = RSP_DATA;
         default:  rsp = RSP_PUTACK;
      endcase
      return rsp;
   endfunction

   function automatic logic is_read(input logic [1:0] msg);
      return (msg == REQ_GETS) || (msg == REQ_GETM);
   endfunction

endpackage

// File: rtl/llc_stub_stats.sv
// Saturating per-message-type request counters for the LLC stub.
// Only instantiated by the top when LLC_STUB_STATS_EN is defined.
module llc_stub_stats
   import llc_stub_pkg::*;
#(
   parameter int CNT_W = 16
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_inc,
   input  logic [1:0]       i_msg,
   output logic [CNT_W-1:0] o_stat_gets,
   output logic [CNT_W-1:0] o_stat_getm,
   output logic [CNT_W-1:0] o_stat_puts,
   output logic [CNT_W-1:0] o_stat_putm
);

   logic [CNT_W-1:0] r_cnt [4];

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         for (int i = 0; i < 4; i++) r_cnt[i] <= '0;
      end else begin
         for (int i = 0; i < 4; i++) begin
            if (i_inc && (i_msg == 2'(i)) && (r_cnt[i] != '1))
               r_cnt[i] <= r_cnt[i] + CNT_W'(1);
         end
      end
   end

   assign o_stat_gets = r_cnt[REQ_GETS];
   assign o_stat_getm = r_cnt[REQ_GETM];
   assign o_stat_puts = r_cnt[REQ_PUTS];
   assign o_stat_putm = r_cnt[REQ_PUTM];

endmodule

// File: rtl/llc_stub_responder.sv
// Directory-side stand-in for one L2: serves GetS/GetM/PutS/PutM from a flat line memory port.
// Defining LLC_STUB_STATS_EN adds saturating per-type request counters and their output ports.
//
// state      | meaning
// ST_IDLE    | ready for the next L2 request (req_ready high)
// ST_MEM_REQ | memory read/write request presented, waiting for mem_req_ready
// ST_MEM_RSP | waiting for read data from memory
// ST_RSP     | response presented to the L2, waiting for rsp_ready
module llc_stub_responder
   import llc_stub_pkg::*;
#(
   parameter int ADDR_W = LINE_ADDR_BITS,
   parameter int LINE_W = BITS_PER_LINE
`ifdef LLC_STUB_STATS_EN
   ,
   parameter int CNT_W  = 16
`endif
) (
   input  logic                       i_clk,
   input  logic                       i_rst,
   input  logic                       i_req_valid,
   output logic                       o_req_ready,
   input  logic [1:0]                 i_req_coh_msg,
   input  logic                       i_req_hprot,
   input  logic [ADDR_W-1:0]          i_req_addr,
   input  logic [LINE_W-1:0]          i_req_line,
   output logic                       o_rsp_valid,
   input  logic                       i_rsp_ready,
   output logic [1:0]                 o_rsp_coh_msg,
   output logic [ADDR_W-1:0]          o_rsp_addr,
   output logic [LINE_W-1:0]          o_rsp_line,
   output logic [INVACK_CNT_BITS-1:0] o_rsp_invack_cnt,
   output logic                       o_mem_req_valid,
   input  logic                       i_mem_req_ready,
   output logic                       o_mem_req_hwrite,
   output logic                       o_mem_req_hprot,
   output logic [ADDR_W-1:0]          o_mem_req_addr,
   output logic [LINE_W-1:0]          o_mem_req_line,
   input  logic                       i_mem_rsp_valid,
   output logic                       o_mem_rsp_ready,
   input  logic [LINE_W-1:0]          i_mem_rsp_line
`ifdef LLC_STUB_STATS_EN
   ,
   output logic [CNT_W-1:0]           o_stat_gets,
   output logic [CNT_W-1:0]           o_stat_getm,
   output logic [CNT_W-1:0]           o_stat_puts,
   output logic [CNT_W-1:0]           o_stat_putm
`endif
);

   llc_state_t        r_state;
   llc_state_t        w_state_nxt;
   logic              r_ready_en;
   logic [1:0]        r_msg;
   logic              r_hprot;
   logic [ADDR_W-1:0] r_addr;
   logic [LINE_W-1:0] r_line;
   logic              w_req_fire;
   logic              w_mem_rsp_fire;

   assign w_req_fire     = i_req_valid && o_req_ready;
   assign w_mem_rsp_fire = i_mem_rsp_valid && o_mem_rsp_ready;

   // r_ready_en keeps req_ready low for the first cycle after reset is released.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state    <= ST_IDLE;
         r_ready_en <= 1'b0;
         r_msg      <= 2'b00;
         r_hprot    <= 1'b0;
         r_addr     <= '0;
         r_line     <= '0;
      end else begin
         r_state    <= w_state_nxt;
         r_ready_en <= 1'b1;
         if (w_req_fire) begin
            r_msg   <= i_req_coh_msg;
            r_hprot <= i_req_hprot;
            r_addr  <= i_req_addr;
            r_line  <= i_req_line;
         end
         if (w_mem_rsp_fire)
            r_line <= i_mem_rsp_line;
      end
   end

   always_comb begin
      w_state_nxt      = r_state;
      o_req_ready      = 1'b0;
      o_mem_req_valid  = 1'b0;
      o_mem_req_hwrite = 1'b0;
      o_mem_rsp_ready  = 1'b0;
      o_rsp_valid      = 1'b0;
      o_rsp_coh_msg    = 2'b00;
      o_rsp_line       = '0;
      case (r_state)
         ST_IDLE: begin
            o_req_ready = r_ready_en;
            if (i_req_valid && r_ready_en)
               w_state_nxt = (i_req_coh_msg == REQ_PUTS) ? ST_RSP : ST_MEM_REQ;
         end
         ST_MEM_REQ: begin
            o_mem_req_valid  = 1'b1;
            o_mem_req_hwrite = (r_msg == REQ_PUTM);
            if (i_mem_req_ready)
               w_state_nxt = is_read(r_msg) ? ST_MEM_RSP : ST_RSP;
         end
         ST_MEM_RSP: begin
            o_mem_rsp_ready = 1'b1;
            if (i_mem_rsp_valid)
               w_state_nxt = ST_RSP;
         end
         ST_RSP: begin
            o_rsp_valid   = 1'b1;
            o_rsp_coh_msg = rsp_for_req(r_msg);
            o_rsp_line    = is_read(r_msg) ? r_line : '0;
            if (i_rsp_ready)
               w_state_nxt = ST_IDLE;
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   assign o_rsp_addr       = r_addr;
   assign o_rsp_invack_cnt = '0;
   assign o_mem_req_hprot  = r_hprot;
   assign o_mem_req_addr   = r_addr;
   assign o_mem_req_line   = r_line;

`ifdef LLC_STUB_STATS_EN
   llc_stub_stats #(
      .CNT_W (CNT_W)
   ) u_stats (
      .i_clk       (i_clk),
      .i_rst       (i_rst),
      .i_inc       (w_req_fire),
      .i_msg       (i_req_coh_msg),
      .o_stat_gets (o_stat_gets),
      .o_stat_getm (o_stat_getm),
      .o_stat_puts (o_stat_puts),
      .o_stat_putm (o_stat_putm)
   );
`endif

endmodule
